// File: rtl/ped_xing_pkg.sv
// ----------------------------------------------------------------------------
// ped_xing_pkg
// Shared types and constants for the pedestrian crossing controller:
//   - state_e       : controller phase encoding (3 bits, every code is a phase)
//   - LAMP_*        : bit positions inside the 5-bit lamp vector
//   - LAMPS_*       : lamp patterns, ordered {ped_red, ped_green, red, yellow, green}
// ----------------------------------------------------------------------------
package ped_xing_pkg;

    typedef enum logic [2:0] {
        LAMPTEST   = 3'd0,
        ROADGREEN  = 3'd1,
        ROADYELLOW = 3'd2,
        ALLRED     = 3'd3,
        PEDGREEN   = 3'd4,
        PEDFLASH   = 3'd5,
        PEDCLEAR   = 3'd6,
        NIGHT      = 3'd7
    } state_e;

    // Bit positions in the lamp vector
    localparam int LAMP_GREEN     = 0;
    localparam int LAMP_YELLOW    = 1;
    localparam int LAMP_RED       = 2;
    localparam int LAMP_PED_GREEN = 3;
    localparam int LAMP_PED_RED   = 4;

    // Lamp patterns {ped_red, ped_green, red, yellow, green}
    localparam logic [4:0] LAMPS_OFF         = 5'b00000;
    localparam logic [4:0] LAMPS_TEST        = 5'b11111;
    localparam logic [4:0] LAMPS_ROAD_GREEN  = 5'b10001;
    localparam logic [4:0] LAMPS_ROAD_YELLOW = 5'b10010;
    localparam logic [4:0] LAMPS_ALL_RED     = 5'b10100;
    localparam logic [4:0] LAMPS_PED_GREEN   = 5'b01100;
    localparam logic [4:0] LAMPS_NIGHT_ON    = 5'b00010;

endpackage

// File: rtl/ped_xing_if.sv
// ----------------------------------------------------------------------------
// ped_xing_if
// Board-side pin bundle of the crossing controller.
//   pin9_ped_button, pin10_night : inputs to the controller (asynchronous)
//   pin4..pin8                   : road / pedestrian lamps
//   pin11_wait                   : "request registered" lamp
// Modports:
//   master : the board / environment (drives button and night, reads lamps)
//   slave  : the controller (reads button and night, drives lamps)
// ----------------------------------------------------------------------------
interface ped_xing_if;
    logic pin9_ped_button;
    logic pin10_night;
    logic pin4_green;
    logic pin5_yellow;
    logic pin6_red;
    logic pin7_ped_green;
    logic pin8_ped_red;
    logic pin11_wait;

    modport master (
        output pin9_ped_button, pin10_night,
        input  pin4_green, pin5_yellow, pin6_red, pin7_ped_green, pin8_ped_red, pin11_wait
    );

    modport slave (
        input  pin9_ped_button, pin10_night,
        output pin4_green, pin5_yellow, pin6_red, pin7_ped_green, pin8_ped_red, pin11_wait
    );
endinterface

// File: rtl/ped_debounce.sv
// ----------------------------------------------------------------------------
// ped_debounce
// 2-FF synchroniser followed by a stable-count debouncer.
//   clk, rst_n : clock, asynchronous active-low reset
//   din_i      : raw asynchronous input
//   level_o    : accepted (debounced) level
//   rise_o     : one-cycle pulse, registered together with a 0->1 acceptance
// The accepted level flips after DEBOUNCE_CYC consecutive cycles in which the
// synchronised input differs from it; any agreeing cycle restarts the count.
// ----------------------------------------------------------------------------
module ped_debounce #(
    parameter int DEBOUNCE_CYC = 160000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din_i,
    output logic level_o,
    output logic rise_o
);
    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);

    logic [1:0]    sync_q;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        level_d = level_q;
        rise_d  = 1'b0;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = sync_q[1];
                rise_d  = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b00;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], din_i};
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
endmodule

// File: rtl/ped_xing_ctrl.sv
// ----------------------------------------------------------------------------
// ped_xing_ctrl
// Demand-driven pedestrian crossing controller with night mode.
//   pin3_clk_16mhz : system clock
//   rst_n          : asynchronous active-low reset (all outputs to 0)
//   bus (slave)    : button / night inputs, five lamps and the wait lamp
// A prescaler produces one-second ticks; sec_cnt counts down the current
// phase. Lamps are decoded from the next state so they switch on the same
// edge as the state register.
// ----------------------------------------------------------------------------
module ped_xing_ctrl
    import ped_xing_pkg::*;
#(
    parameter int TIMER_SCALE  = 16000000,
    parameter int LAMPTEST_S   = 3,
    parameter int GREEN_MIN_S  = 10,
    parameter int YELLOW_S     = 4,
    parameter int ALLRED_S     = 2,
    parameter int PED_GREEN_S  = 8,
    parameter int PED_FLASH_S  = 4,
    parameter int FLASH_TICKS  = 8000000,
    parameter int DEBOUNCE_CYC = 160000
) (
    input  logic pin3_clk_16mhz,
    input  logic rst_n,
    ped_xing_if.slave bus
);
    localparam int PW = $clog2(TIMER_SCALE);
    localparam logic [PW-1:0] PS_MAX = PW'(TIMER_SCALE - 1);
    localparam int FW = (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS) : 1;
    localparam logic [FW-1:0] FL_MAX = FW'(FLASH_TICKS - 1);

    state_e        state_q, state_d;
    logic [PW-1:0] prescaler_q, prescaler_d;
    logic [7:0]    sec_cnt_q, sec_cnt_d;
    logic [FW-1:0] flash_cnt_q, flash_cnt_d;
    logic          flash_q, flash_d;
    logic          min_done_q, min_done_d;
    logic          req_q, req_d;
    logic [4:0]    lamps_q, lamps_d;
    logic          wait_q;
    logic [1:0]    night_sync_q;
    logic          night_s;
    logic          btn_level, btn_rise;
    logic          tick, expired, entering;

    ped_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_debounce (
        .clk     (pin3_clk_16mhz),
        .rst_n   (rst_n),
        .din_i   (bus.pin9_ped_button),
        .level_o (btn_level),
        .rise_o  (btn_rise)
    );

    assign night_s = night_sync_q[1];

    // Reload value for sec_cnt on phase entry (NIGHT is untimed)
    function automatic logic [7:0] phase_len(input state_e s);
        case (s)
            LAMPTEST:   return 8'(LAMPTEST_S - 1);
            ROADGREEN:  return 8'(GREEN_MIN_S - 1);
            ROADYELLOW: return 8'(YELLOW_S - 1);
            ALLRED:     return 8'(ALLRED_S - 1);
            PEDGREEN:   return 8'(PED_GREEN_S - 1);
            PEDFLASH:   return 8'(PED_FLASH_S - 1);
            PEDCLEAR:   return 8'(ALLRED_S - 1);
            default:    return 8'd0;
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        min_done_d = min_done_q;
        tick       = (prescaler_q == PS_MAX);
        expired    = tick && (sec_cnt_q == 8'd0);

        case (state_q)
            LAMPTEST:   if (expired) state_d = night_s ? NIGHT : ROADGREEN;
            ROADGREEN: begin
                if (night_s) begin
                    state_d = ROADYELLOW;
                end else begin
                    if (expired) min_done_d = 1'b1;
                    // A request already pending leaves on the expiry edge itself
                    if ((min_done_q || expired) && req_q) state_d = ROADYELLOW;
                end
            end
            ROADYELLOW: if (expired) state_d = night_s ? NIGHT : ALLRED;
            ALLRED:     if (expired) state_d = req_q ? PEDGREEN : ROADGREEN;
            PEDGREEN:   if (expired) state_d = PEDFLASH;
            PEDFLASH:   if (expired) state_d = PEDCLEAR;
            PEDCLEAR:   if (expired) state_d = ROADGREEN;
            NIGHT:      if (!night_s) state_d = ALLRED;
            default:    state_d = LAMPTEST;
        endcase

        entering = (state_d != state_q);
        if (entering) begin
            prescaler_d = '0;
            sec_cnt_d   = phase_len(state_d);
            flash_cnt_d = '0;
            flash_d     = 1'b1;
            if (state_d == ROADGREEN) min_done_d = 1'b0;
        end else begin
            prescaler_d = tick ? '0 : prescaler_q + 1'b1;
            sec_cnt_d   = (tick && sec_cnt_q != 8'd0) ? sec_cnt_q - 8'd1 : sec_cnt_q;
            if (flash_cnt_q == FL_MAX) begin
                flash_cnt_d = '0;
                flash_d     = ~flash_q;
            end else begin
                flash_cnt_d = flash_cnt_q + 1'b1;
                flash_d     = flash_q;
            end
        end

        // Clearing on PEDGREEN entry beats a simultaneous button edge
        if (entering && state_d == PEDGREEN) req_d = 1'b0;
        else                                 req_d = req_q | btn_rise;

        case (state_d)
            LAMPTEST:   lamps_d = LAMPS_TEST;
            ROADGREEN:  lamps_d = LAMPS_ROAD_GREEN;
            ROADYELLOW: lamps_d = LAMPS_ROAD_YELLOW;
            ALLRED:     lamps_d = LAMPS_ALL_RED;
            PEDGREEN:   lamps_d = LAMPS_PED_GREEN;
            PEDFLASH:   lamps_d = flash_d ? LAMPS_PED_GREEN : LAMPS_ALL_RED;
            PEDCLEAR:   lamps_d = LAMPS_ALL_RED;
            NIGHT:      lamps_d = flash_d ? LAMPS_NIGHT_ON : LAMPS_OFF;
            default:    lamps_d = LAMPS_OFF;
        endcase
    end

    always_ff @(posedge pin3_clk_16mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= LAMPTEST;
            prescaler_q  <= '0;
            sec_cnt_q    <= 8'(LAMPTEST_S - 1);
            flash_cnt_q  <= '0;
            flash_q      <= 1'b1;
            min_done_q   <= 1'b0;
            req_q        <= 1'b0;
            lamps_q      <= LAMPS_OFF;
            wait_q       <= 1'b0;
            night_sync_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            prescaler_q  <= prescaler_d;
            sec_cnt_q    <= sec_cnt_d;
            flash_cnt_q  <= flash_cnt_d;
            flash_q      <= flash_d;
            min_done_q   <= min_done_d;
            req_q        <= req_d;
            lamps_q      <= lamps_d;
            wait_q       <= req_d;
            night_sync_q <= {night_sync_q[0], bus.pin10_night};
        end
    end

    assign bus.pin4_green     = lamps_q[LAMP_GREEN];
    assign bus.pin5_yellow    = lamps_q[LAMP_YELLOW];
    assign bus.pin6_red       = lamps_q[LAMP_RED];
    assign bus.pin7_ped_green = lamps_q[LAMP_PED_GREEN];
    assign bus.pin8_ped_red   = lamps_q[LAMP_PED_RED];
    assign bus.pin11_wait     = wait_q;

    // The debounced level itself is only needed for its rising edge
    logic unused_level;
    assign unused_level = btn_level;
endmodule

// File: tb/tb_ped_xing_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ped_xing_ctrl
// Table-driven bench: each row holds button/night levels, the expected
// {lamps, wait} and how many consecutive cycles they must hold. Inputs are
// driven on the falling edge, outputs sampled on the following falling edge.
// Bench timing: TIMER_SCALE=4, so a D-second phase is 4*D cycles.
// ----------------------------------------------------------------------------
module tb_ped_xing_ctrl;

    typedef struct {
        logic       btn;
        logic       night;
        logic [4:0] lamps;
        logic       wt;
        int         n;
    } row_t;

    logic clk;
    logic rst_n;
    int   nchecks;
    int   nfail;
    row_t tbl_a[$];
    row_t tbl_b[$];

    // Rows of tbl_b that bring the design into the middle of PEDFLASH
    localparam int PREFIX = 9;

    ped_xing_if bus();

    ped_xing_ctrl #(
        .TIMER_SCALE (4),
        .LAMPTEST_S  (2),
        .GREEN_MIN_S (3),
        .YELLOW_S    (2),
        .ALLRED_S    (1),
        .PED_GREEN_S (2),
        .PED_FLASH_S (2),
        .FLASH_TICKS (2),
        .DEBOUNCE_CYC(3)
    ) dut (
        .pin3_clk_16mhz(clk),
        .rst_n         (rst_n),
        .bus           (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic row_t mk(input logic b, input logic nt, input logic [4:0] l,
                                input logic w, input int n);
        row_t r;
        r.btn = b; r.night = nt; r.lamps = l; r.wt = w; r.n = n;
        return r;
    endfunction

    function automatic logic [5:0] obs();
        return {bus.pin8_ped_red, bus.pin7_ped_green, bus.pin6_red,
                bus.pin5_yellow, bus.pin4_green, bus.pin11_wait};
    endfunction

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        nchecks++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s lamps+wait got=%b want=%b", name, act, exp);
        end
    endtask

    // Enter at a falling edge; leaves at a falling edge
    task automatic run_row(input string tag, input int idx, input row_t r);
        for (int c = 0; c < r.n; c++) begin
            bus.pin9_ped_button = r.btn;
            bus.pin10_night     = r.night;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("%s.row%0d.c%0d", tag, idx, c), obs(), {r.lamps, r.wt});
        end
        $display("%s row %0d: btn=%b night=%b lamps=%b wait=%b x%0d",
                 tag, idx, r.btn, r.night, r.lamps, r.wt, r.n);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n               = 1'b0;
        bus.pin9_ped_button = 1'b0;
        bus.pin10_night     = 1'b0;
        repeat (3) @(negedge clk);
        check({tag, ".in_reset"}, obs(), 6'b000000);
        rst_n = 1'b1;
        $display("%s reset released", tag);
    endtask

    initial begin
        nchecks = 0;
        nfail   = 0;
        rst_n   = 1'b0;
        bus.pin9_ped_button = 1'b0;
        bus.pin10_night     = 1'b0;

        // Idle road, plus a button glitch shorter than the debounce window
        tbl_a.push_back(mk(0, 0, 5'b11111, 0, 7));   // LAMPTEST; green on the 8th edge
        tbl_a.push_back(mk(0, 0, 5'b10001, 0, 200));
        tbl_a.push_back(mk(1, 0, 5'b10001, 0, 2));   // 2-cycle press is ignored
        tbl_a.push_back(mk(0, 0, 5'b10001, 0, 30));

        // Full pedestrian cycle from a fresh green, then night from green,
        // then night requested during PEDGREEN
        tbl_b.push_back(mk(0, 0, 5'b11111, 0, 7));   // 0
        tbl_b.push_back(mk(0, 0, 5'b10001, 0, 1));   // 1 green entry edge
        tbl_b.push_back(mk(1, 0, 5'b10001, 0, 5));   // 2 sync + debounce latency
        tbl_b.push_back(mk(1, 0, 5'b10001, 1, 5));   // 3 request latched
        tbl_b.push_back(mk(0, 0, 5'b10001, 1, 1));   // 4 green totals 12 cycles
        tbl_b.push_back(mk(0, 0, 5'b10010, 1, 8));   // 5 yellow
        tbl_b.push_back(mk(0, 0, 5'b10100, 1, 4));   // 6 all red
        tbl_b.push_back(mk(0, 0, 5'b01100, 0, 8));   // 7 ped green, wait drops
        tbl_b.push_back(mk(0, 0, 5'b01100, 0, 2));   // 8 flash on
        tbl_b.push_back(mk(0, 0, 5'b10100, 0, 2));   // 9 flash off
        tbl_b.push_back(mk(0, 0, 5'b01100, 0, 2));   // 10
        tbl_b.push_back(mk(0, 0, 5'b10100, 0, 2));   // 11
        tbl_b.push_back(mk(0, 0, 5'b10100, 0, 4));   // 12 ped clear
        tbl_b.push_back(mk(0, 0, 5'b10001, 0, 20));  // 13 back to green
        tbl_b.push_back(mk(0, 1, 5'b10001, 0, 2));   // 14 night synchroniser delay
        tbl_b.push_back(mk(0, 1, 5'b10010, 0, 8));   // 15 yellow, min green ignored
        tbl_b.push_back(mk(0, 1, 5'b00010, 0, 2));   // 16 night flashing
        tbl_b.push_back(mk(0, 1, 5'b00000, 0, 2));   // 17
        tbl_b.push_back(mk(0, 1, 5'b00010, 0, 2));   // 18
        tbl_b.push_back(mk(0, 1, 5'b00000, 0, 2));   // 19
        tbl_b.push_back(mk(0, 0, 5'b00010, 0, 2));   // 20 night falling, sync delay
        tbl_b.push_back(mk(0, 0, 5'b10100, 0, 4));   // 21 all red
        tbl_b.push_back(mk(0, 0, 5'b10001, 0, 10));  // 22 green, min expires
        tbl_b.push_back(mk(1, 0, 5'b10001, 0, 5));   // 23
        tbl_b.push_back(mk(1, 0, 5'b10001, 1, 1));   // 24 leaves next edge
        tbl_b.push_back(mk(1, 0, 5'b10010, 1, 4));   // 25
        tbl_b.push_back(mk(0, 0, 5'b10010, 1, 4));   // 26
        tbl_b.push_back(mk(0, 0, 5'b10100, 1, 4));   // 27
        tbl_b.push_back(mk(0, 1, 5'b01100, 0, 8));   // 28 night ignored during ped cycle
        tbl_b.push_back(mk(0, 1, 5'b01100, 0, 2));   // 29
        tbl_b.push_back(mk(0, 1, 5'b10100, 0, 2));   // 30
        tbl_b.push_back(mk(0, 1, 5'b01100, 0, 2));   // 31
        tbl_b.push_back(mk(0, 1, 5'b10100, 0, 2));   // 32
        tbl_b.push_back(mk(0, 1, 5'b10100, 0, 4));   // 33 ped clear
        tbl_b.push_back(mk(0, 1, 5'b10001, 0, 1));   // 34 green for one cycle
        tbl_b.push_back(mk(0, 1, 5'b10010, 0, 8));   // 35 yellow
        tbl_b.push_back(mk(0, 1, 5'b00010, 0, 2));   // 36 night
        tbl_b.push_back(mk(0, 1, 5'b00000, 0, 2));   // 37

        do_reset("idle");
        for (int i = 0; i < tbl_a.size(); i++) run_row("idle", i, tbl_a[i]);

        do_reset("cycle");
        for (int i = 0; i < tbl_b.size(); i++) run_row("cycle", i, tbl_b[i]);

        // Asynchronous reset in the middle of PEDFLASH
        do_reset("midflash");
        for (int i = 0; i < PREFIX; i++) run_row("midflash", i, tbl_b[i]);
        #2;
        rst_n = 1'b0;
        #1;
        check("midflash.async_clear", obs(), 6'b000000);
        @(negedge clk);
        check("midflash.reset_hold", obs(), 6'b000000);
        rst_n = 1'b1;
        $display("midflash reset pulsed and released");
        run_row("restart", 0, tbl_a[0]);
        run_row("restart", 1, mk(0, 0, 5'b10001, 0, 20));

        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end

endmodule
